toy_cpu_top: RTL and testbench



---
 rtl/toy_cpu_pkg.sv | 49 ++++
 rtl/toy_cpu_openmips.sv | 88 ++++++++
 rtl/toy_cpu_ram.sv | 27 ++
 rtl/toy_cpu_regfile.sv | 40 ++++
 rtl/toy_cpu_top.sv | 35 +++
 tb/tb_toy_cpu_top.sv | 177 +++++++++++++++++
 6 files changed

// File: rtl/toy_cpu_pkg.sv
// Shared types, opcode constants and ALU helpers for the toy MIPS-subset CPU.
package toy_cpu_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;

    localparam opcode_t OP_ANDI = 6'h0C;
    localparam opcode_t OP_ORI  = 6'h0D;
    localparam opcode_t OP_XORI = 6'h0E;
    localparam opcode_t OP_LUI  = 6'h0F;

    localparam word_t NOP_INSN = 32'h0000_0000;

    // Decoded instruction travelling from ID to EX.
    typedef struct packed {
        logic     we;
        opcode_t  op;
        reg_idx_t rd;
        word_t    rs_val;
        logic [15:0] imm;
    } id_ex_t;

    // Result travelling through EX/MEM and MEM/WB.
    typedef struct packed {
        logic     we;
        reg_idx_t rd;
        word_t    result;
    } result_t;

    // True for opcodes that write a register; unknown or X/Z opcodes fall to default.
    function automatic logic op_writes(input opcode_t op);
        case (op)
            OP_ORI, OP_ANDI, OP_XORI, OP_LUI: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic word_t alu(input opcode_t op, input word_t a, input logic [15:0] imm);
        case (op)
            OP_ORI:  return a | {16'h0000, imm};
            OP_ANDI: return a & {16'h0000, imm};
            OP_XORI: return a ^ {16'h0000, imm};
            OP_LUI:  return {imm, 16'h0000};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/toy_cpu_openmips.sv
// Five-stage pipelined core: IF, ID, EX, MEM, WB. No stalls, no branches;
// dependent chains are resolved by forwarding EX and MEM results into ID.
// Build option: define TOY_CPU_TRACE_EN to log every retired register write.
module toy_cpu_openmips
    import toy_cpu_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] imem_idx_o,
    input  word_t         imem_data_i
);

    word_t   pc_q, pc_d;
    word_t   if_id_q, if_id_d;
    id_ex_t  id_ex_q, id_ex_d;
    result_t ex_mem_q, ex_mem_d;
    result_t mem_wb_q, mem_wb_d;

    opcode_t  id_op;
    reg_idx_t id_rs, id_rt;
    word_t    rf_rs_val, unused_rt_val, id_rs_val, ex_result;

    assign imem_idx_o = pc_q[2 +: AW];
    assign id_op      = if_id_q[31:26];
    assign id_rs      = if_id_q[25:21];
    assign id_rt      = if_id_q[20:16];
    assign ex_result  = alu(id_ex_q.op, id_ex_q.rs_val, id_ex_q.imm);

    toy_cpu_regfile regfile (
        .clk       (clk),
        .rst       (rst),
        .raddr_a_i (id_rs),
        .rdata_a_o (rf_rs_val),
        .raddr_b_i (id_rt),
        .rdata_b_o (unused_rt_val),
        .we_i      (mem_wb_q.we),
        .waddr_i   (mem_wb_q.rd),
        .wdata_i   (mem_wb_q.result)
    );

    // Next-state for PC and every pipeline register, including ID operand forwarding.
    always_comb begin
        pc_d    = pc_q + 32'd4;
        if_id_d = imem_data_i;

        // Youngest producer wins; we is never set for rd==0, so $0 is never forwarded.
        id_rs_val = rf_rs_val;
        if (id_ex_q.we && id_ex_q.rd == id_rs)        id_rs_val = ex_result;
        else if (ex_mem_q.we && ex_mem_q.rd == id_rs) id_rs_val = ex_mem_q.result;

        id_ex_d.we     = op_writes(id_op) && (id_rt != '0);
        id_ex_d.op     = id_op;
        id_ex_d.rd     = id_rt;
        id_ex_d.rs_val = id_rs_val;
        id_ex_d.imm    = if_id_q[15:0];

        ex_mem_d = '{we: id_ex_q.we, rd: id_ex_q.rd, result: ex_result};
        mem_wb_d = ex_mem_q;
    end

    // PC and pipeline registers; reset flushes every stage to a NOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            if_id_q  <= NOP_INSN;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            pc_q     <= pc_d;
            if_id_q  <= if_id_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

`ifdef TOY_CPU_TRACE_EN
    // Report each register write as it retires from WB.
    always_ff @(posedge clk) begin
        if (!rst && mem_wb_q.we && mem_wb_q.rd != '0)
            $display("%0t wb r%0d = %h", $time, mem_wb_q.rd, mem_wb_q.result);
    end
`endif

endmodule

// File: rtl/toy_cpu_ram.sv
// Word-addressed instruction RAM with a combinational read port.
// The write port exists for completeness; the core never drives it.
module toy_cpu_ram
    import toy_cpu_pkg::*;
#(
    parameter int RAM_DEPTH = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  word_t         wdata_i,
    input  logic [AW-1:0] raddr_i,
    output word_t         rdata_o
);

    word_t memory [0:RAM_DEPTH-1];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        // NOTE: memory contents are intentionally not reset; the program is loaded externally.
        if (we_i) memory[waddr_i] <= wdata_i;
    end

    assign rdata_o = memory[raddr_i];

endmodule

// File: rtl/toy_cpu_regfile.sv
// 32 x 32-bit register file: two read ports, one write port, write-through bypass.
// regs[0] is never written and always reads zero.
module toy_cpu_regfile
    import toy_cpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t raddr_a_i,
    output word_t    rdata_a_o,
    input  reg_idx_t raddr_b_i,
    output word_t    rdata_b_o,
    input  logic     we_i,
    input  reg_idx_t waddr_i,
    input  word_t    wdata_i
);

    word_t regs [0:31];

    // Architectural register state; reset clears every register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    // Read ports see a same-cycle write so WB needs no separate forwarding path.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        rdata_a_o = regs[raddr_a_i];
        rdata_b_o = regs[raddr_b_i];
        if (raddr_a_i == '0)                         rdata_a_o = '0;
        else if (we_i && waddr_i == raddr_a_i)       rdata_a_o = wdata_i;
        if (raddr_b_i == '0)                         rdata_b_o = '0;
        else if (we_i && waddr_i == raddr_b_i)       rdata_b_o = wdata_i;
    end

endmodule

// File: rtl/toy_cpu_top.sv
// Top-level integration: pipelined core `openmips` fetching from instruction RAM `ram`.
// No outputs; architectural state is observed hierarchically.
// Build option: TOY_CPU_TRACE_EN enables a write-back trace in the core.
module toy_cpu_top
    import toy_cpu_pkg::*;
#(
    parameter int RAM_DEPTH = 1024
) (
    input logic clk,
    input logic rst
);

    // RAM_DEPTH is expected to be a power of two so the index wraps naturally.
    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic [AW-1:0] imem_idx;
    word_t         imem_data;

    toy_cpu_openmips #(.AW(AW)) openmips (
        .clk         (clk),
        .rst         (rst),
        .imem_idx_o  (imem_idx),
        .imem_data_i (imem_data)
    );

    toy_cpu_ram #(.RAM_DEPTH(RAM_DEPTH), .AW(AW)) ram (
        .clk     (clk),
        .we_i    (1'b0),
        .waddr_i ('0),
        .wdata_i ('0),
        .raddr_i (imem_idx),
        .rdata_o (imem_data)
    );

endmodule

// File: tb/tb_toy_cpu_top.sv
// Self-checking bench for toy_cpu_top: table-driven programs, randomized programs,
// RAM wraparound and mid-program reset, all against an instruction-level model.
module tb_toy_cpu_top;
    import toy_cpu_pkg::*;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    word_t shadow [DEPTH];
    word_t mdl    [32];

    toy_cpu_top #(.RAM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Architectural model: execute n instructions in program order from word 0.
    function automatic void model_run(input int n);
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        for (int k = 0; k < n; k++) begin
            word_t ins, imm_z, v;
            int    rs, rt;
            bit    w;
            ins   = shadow[k % DEPTH];
            rs    = int'(ins[25:21]);
            rt    = int'(ins[20:16]);
            imm_z = {16'h0000, ins[15:0]};
            w     = 1'b1;
            v     = '0;
            case (ins[31:26])
                6'h0D:   v = mdl[rs] | imm_z;
                6'h0C:   v = mdl[rs] & imm_z;
                6'h0E:   v = mdl[rs] ^ imm_z;
                6'h0F:   v = imm_z << 16;
                default: w = 1'b0;
            endcase
            if (w && rt != 0) mdl[rt] = v;
        end
    endfunction

    // Compare all 32 registers against the model; reports the lowest differing one.
    task automatic check_regs(input string tag);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--)
            if (dut.openmips.regfile.regs[i] !== mdl[i]) idx = i;
        check($sformatf("%s r%0d", tag, idx), dut.openmips.regfile.regs[idx], mdl[idx]);
    endtask

    // Load shadow into RAM under reset, verify cleared state, release reset at a negedge.
    task automatic start(input int hold);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) dut.ram.memory[i] <= shadow[i];
        repeat (hold) @(negedge clk);
        model_run(0);
        check_regs("reset_state");
        rst = 1'b0;
    endtask

    // Instruction k retires at the posedge ending cycle k+5, so after c edges c-4 have retired.
    task automatic run_cycles(input int n, input string tag);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            model_run((c > 4) ? c - 4 : 0);
            check_regs($sformatf("%s c%0d", tag, c));
        end
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < DEPTH; i++) shadow[i] = NOP_INSN;
    endtask

    typedef struct {
        string name;
        word_t prog [4];
        int    nchk;
        int    rid  [4];
        word_t rval [4];
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{"basic",   '{32'h34021100, 32'h34030020, 32'h3404ff00, 32'h3405ffff},
                    4, '{2, 3, 4, 5}, '{32'h00001100, 32'h00000020, 32'h0000ff00, 32'h0000ffff}};
        vecs[1] = '{"chain",   '{32'h34021100, 32'h34420001, 32'h34420010, 32'h34420100},
                    1, '{2, 0, 0, 0}, '{32'h00001111, 32'h0, 32'h0, 32'h0}};
        vecs[2] = '{"logic",   '{32'h3C031234, 32'h3463abcd, 32'h3064ff00, 32'h3865ffff},
                    3, '{3, 4, 5, 0}, '{32'h1234abcd, 32'h0000ab00, 32'h12345432, 32'h0}};
        vecs[3] = '{"zero",    '{32'h3400ffff, 32'h34060000, 32'hFC000000, 32'h00000000},
                    2, '{0, 6, 0, 0}, '{32'h0, 32'h0, 32'h0, 32'h0}};
        vecs[4] = '{"unknown", '{32'h3402abcd, 32'hFC42ffff, 32'h3400ffff, 32'h34060000},
                    3, '{2, 0, 6, 0}, '{32'h0000abcd, 32'h0, 32'h0, 32'h0}};

        // Directed programs: per-cycle timing against the model, then fixed final values.
        for (int v = 0; v < 5; v++) begin
            clear_shadow();
            for (int j = 0; j < 4; j++) shadow[j] = vecs[v].prog[j];
            start(10);
            run_cycles(100, vecs[v].name);
            for (int j = 0; j < vecs[v].nchk; j++)
                check($sformatf("%s final r%0d", vecs[v].name, vecs[v].rid[j]),
                      dut.openmips.regfile.regs[vecs[v].rid[j]], vecs[v].rval[j]);
        end

        // Randomized programs with a small register window to force dependencies.
        for (int t = 0; t < 4; t++) begin
            clear_shadow();
            for (int k = 0; k < 24; k++) begin
                opcode_t op;
                case ($urandom_range(0, 4))
                    0:       op = OP_ANDI;
                    1:       op = OP_ORI;
                    2:       op = OP_XORI;
                    3:       op = OP_LUI;
                    default: op = 6'($urandom_range(16, 63));
                endcase
                shadow[k] = {op, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 16'($urandom)};
            end
            start(2);
            run_cycles(32, $sformatf("rand%0d", t));
        end

        // RAM index wraparound: the toggles execute once per pass through memory.
        clear_shadow();
        shadow[0]         = 32'h38420001;
        shadow[DEPTH - 1] = 32'h38630010;
        start(3);
        run_cycles(3 * DEPTH + 8, "wrap");
        check("wrap final r2", dut.openmips.regfile.regs[2], 32'h00000000);
        check("wrap final r3", dut.openmips.regfile.regs[3], 32'h00000010);

        // One-cycle reset mid-program: state clears, then the program replays from word 0.
        clear_shadow();
        shadow[0] = 32'h3C031234;
        shadow[1] = 32'h3463abcd;
        shadow[2] = 32'h3064ff00;
        shadow[3] = 32'h3865ffff;
        start(2);
        run_cycles(7, "pre_reset");
        rst = 1'b1;
        @(negedge clk);
        model_run(0);
        check_regs("mid_reset");
        rst = 1'b0;
        run_cycles(20, "restart");
        check("restart final r3", dut.openmips.regfile.regs[3], 32'h1234abcd);
        check("restart final r4", dut.openmips.regfile.regs[4], 32'h0000ab00);
        check("restart final r5", dut.openmips.regfile.regs[5], 32'h12345432);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
